program_counter: RTL and testbench

//   Hack-style CPU program counter: a WIDTH-bit register holding the address of the next instruction.
//   It supports reset-to-vector, parallel load (jump target from the ALU/A-register path), increment and hold.
//   It sits between the CPU control decode (load/inc) and instruction ROM addressing (out).

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_incrementer.sv | 15 +
 rtl/program_counter.sv | 70 +++++++
 tb/tb_program_counter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the Hack-style program counter.
// Holds the width/reset-vector defaults and the update-priority decode.
package pc_pkg;

  localparam int PC_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_RESET
  } pc_op_e;

  // Reset is tested first so X on load/inc never reaches the op while reset is high.
  function automatic pc_op_e pc_decode(input logic rst, input logic load, input logic inc);
    if (rst) return PC_RESET;
    if (load) return PC_LOAD;
    if (inc) return PC_INC;
    return PC_HOLD;
  endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Combinational WIDTH-bit +1 with carry out.
// The carry marks the all-ones to zero rollover.
module pc_incrementer
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/program_counter.sv
// Hack-style program counter: reset-to-vector, load, increment, hold.
// Optional registered rollover flag 'wrap' when PC_WRAP_FLAG_EN is defined.
module program_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_p0;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] inc_sum;
  logic             inc_carry;

  pc_incrementer #(
    .WIDTH(WIDTH)
  ) u_inc (
    .a        (pc_p0),
    .sum      (inc_sum),
    .carry_out(inc_carry)
  );

  assign op = pc_decode(reset, load, inc);

  always_comb begin
    pc_nxt = pc_p0;
    case (op)
      PC_RESET: pc_nxt = RESET_VECTOR;
      PC_LOAD:  pc_nxt = in;
      PC_INC:   pc_nxt = inc_sum;
      default:  pc_nxt = pc_p0;
    endcase
  end

  // Stage p0: the PC register itself; out is driven straight from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_p0 <= RESET_VECTOR;
    else       pc_p0 <= pc_nxt;
  end

  assign out = pc_p0;

`ifdef PC_WRAP_FLAG_EN
  logic wrap_p0;

  // Only an increment out of all-ones raises the flag; load of zero does not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap_p0 <= 1'b0;
    else       wrap_p0 <= (op == PC_INC) && inc_carry;
  end

  assign wrap = wrap_p0;
`else
  logic unused_carry;
  assign unused_carry = inc_carry;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter; wrap is checked when PC_WRAP_FLAG_EN is defined.
`timescale 1ns/1ps
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        inc;
  logic [15:0] in;
  logic [15:0] out;
`ifdef PC_WRAP_FLAG_EN
  logic        wrap;
`endif

  program_counter dut (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .inc  (inc),
    .in   (in),
    .out  (out)
`ifdef PC_WRAP_FLAG_EN
    ,
    .wrap (wrap)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] q;
    logic        w;
    string       tag;
  } exp_t;

  typedef struct {
    logic        ld;
    logic        ic;
    logic [15:0] din;
    logic [15:0] q;
    logic        w;
  } row_t;

  exp_t sb[$];

  task automatic push_exp(input logic [15:0] q, input logic w, input string tag);
    exp_t e;
    e.q   = q;
    e.w   = w;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    row_t rows[$];
    reset = 1'b0; load = 1'b0; inc = 1'b0; in = 16'h0000;
    #2;
    reset = 1'b1;
    push_exp(16'h0000, 1'b0, "reset_async");
    #1;
    e = sb.pop_front();
    checks++;
    if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
`ifdef PC_WRAP_FLAG_EN
    checks++;
    if (wrap !== e.w) begin failures++; $display("FAIL %s wrap=%b expected=%b", e.tag, wrap, e.w); end
`endif
    push_exp(16'h0000, 1'b0, "reset_held");
    tick();
    e = sb.pop_front();
    checks++;
    if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
    reset = 1'b0;
    rows = '{'{1'b0, 1'b0, 16'h1111, 16'h0000, 1'b0},
             '{1'b0, 1'b0, 16'h2222, 16'h0000, 1'b0}};
    foreach (rows[i]) begin
      load = rows[i].ld; inc = rows[i].ic; in = rows[i].din;
      push_exp(rows[i].q, rows[i].w, $sformatf("reset_release_hold[%0d]", i));
      tick();
      e = sb.pop_front();
      checks++;
      if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
    end
  endtask

  task automatic test_inc();
    exp_t e;
    row_t rows[$];
    rows = '{'{1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0},
             '{1'b0, 1'b1, 16'h0000, 16'h0002, 1'b0},
             '{1'b0, 1'b1, 16'h0000, 16'h0003, 1'b0},
             '{1'b0, 1'b0, 16'h8285, 16'h0003, 1'b0},
             '{1'b0, 1'b0, 16'h7001, 16'h0003, 1'b0},
             '{1'b0, 1'b1, 16'h8285, 16'h0004, 1'b0}};
    foreach (rows[i]) begin
      load = rows[i].ld; inc = rows[i].ic; in = rows[i].din;
      push_exp(rows[i].q, rows[i].w, $sformatf("inc[%0d]", i));
      #2 in = ~rows[i].din;
      tick();
      e = sb.pop_front();
      checks++;
      if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
    end
  endtask

  task automatic test_load_priority();
    exp_t e;
    row_t rows[$];
    rows = '{'{1'b1, 1'b1, 16'h8285, 16'h8285, 1'b0},
             '{1'b1, 1'b1, 16'h8285, 16'h8285, 1'b0},
             '{1'b1, 1'b0, 16'h8285, 16'h8285, 1'b0}};
    foreach (rows[i]) begin
      load = rows[i].ld; inc = rows[i].ic; in = rows[i].din;
      push_exp(rows[i].q, rows[i].w, $sformatf("load_wins[%0d]", i));
      tick();
      e = sb.pop_front();
      checks++;
      if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
    end
  endtask

  task automatic test_count_hold();
    exp_t e;
    row_t rows[$];
    rows = '{'{1'b0, 1'b1, 16'h0000, 16'h8286, 1'b0},
             '{1'b0, 1'b1, 16'h0000, 16'h8287, 1'b0},
             '{1'b0, 1'b0, 16'h0000, 16'h8287, 1'b0},
             '{1'b0, 1'b0, 16'hFFFF, 16'h8287, 1'b0}};
    foreach (rows[i]) begin
      load = rows[i].ld; inc = rows[i].ic; in = rows[i].din;
      push_exp(rows[i].q, rows[i].w, $sformatf("count_hold[%0d]", i));
      tick();
      e = sb.pop_front();
      checks++;
      if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    row_t rows[$];
    rows = '{'{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0},
             '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1},
             '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0},
             '{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0},
             '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1},
             '{1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0},
             '{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0},
             '{1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0},
             '{1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0},
             '{1'b0, 1'b1, 16'h0000, 16'h8000, 1'b0}};
    foreach (rows[i]) begin
      load = rows[i].ld; inc = rows[i].ic; in = rows[i].din;
      push_exp(rows[i].q, rows[i].w, $sformatf("wrap[%0d]", i));
      tick();
      e = sb.pop_front();
      checks++;
      if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
`ifdef PC_WRAP_FLAG_EN
      checks++;
      if (wrap !== e.w) begin failures++; $display("FAIL %s wrap=%b expected=%b", e.tag, wrap, e.w); end
`endif
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    load = 1'b1; inc = 1'b0; in = 16'hFFFF;
    push_exp(16'hFFFF, 1'b0, "areset_setup_load");
    tick();
    e = sb.pop_front();
    checks++;
    if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
    load = 1'b0; inc = 1'b1;
    push_exp(16'h0000, 1'b1, "areset_setup_inc");
    tick();
    e = sb.pop_front();
    load = 1'b1; inc = 1'b0; in = 16'h1234;
    push_exp(16'h1234, 1'b0, "areset_pre_load");
    tick();
    e = sb.pop_front();
    checks++;
    if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
    #3;
    load = 1'b1; in = 16'h5A5A; reset = 1'b1;
    push_exp(16'h0000, 1'b0, "areset_midcycle");
    #1;
    e = sb.pop_front();
    checks++;
    if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
    for (int i = 0; i < 2; i++) begin
      load = 1'bx; inc = 1'bx;
      push_exp(16'h0000, 1'b0, $sformatf("areset_dominates[%0d]", i));
      tick();
      e = sb.pop_front();
      checks++;
      if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
    end
    reset = 1'b0; load = 1'b1; inc = 1'b0; in = 16'h5A5A;
    push_exp(16'h5A5A, 1'b0, "areset_release_load");
    tick();
    e = sb.pop_front();
    checks++;
    if (out !== e.q) begin failures++; $display("FAIL %s out=%h expected=%h", e.tag, out, e.q); end
  endtask

`ifdef PC_WRAP_FLAG_EN
  task automatic test_wrap_async_clear();
    exp_t e;
    load = 1'b1; inc = 1'b0; in = 16'hFFFF;
    tick();
    load = 1'b0; inc = 1'b1;
    push_exp(16'h0000, 1'b1, "wrap_before_reset");
    tick();
    e = sb.pop_front();
    checks++;
    if (wrap !== e.w) begin failures++; $display("FAIL %s wrap=%b expected=%b", e.tag, wrap, e.w); end
    #2;
    reset = 1'b1;
    push_exp(16'h0000, 1'b0, "wrap_async_clear");
    #1;
    e = sb.pop_front();
    checks++;
    if (wrap !== e.w) begin failures++; $display("FAIL %s wrap=%b expected=%b", e.tag, wrap, e.w); end
    tick();
    reset = 1'b0; inc = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_inc();
    test_load_priority();
    test_count_hold();
    test_wrap();
    test_async_reset();
`ifdef PC_WRAP_FLAG_EN
    test_wrap_async_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
